// File: rtl/lpc_io_decoder.sv
// ---------------------------------------------------------------------------
// lpc_io_decoder
//
// Peripheral-side LPC front end for the FPGA register file. Decodes host LPC
// I/O read and write cycles that fall inside a 2**WIN_BITS byte window at
// IO_BASE. It also drives TAR, SYNC and the read-data nibbles, and it presents
// a byte-wide register port to the downstream register block. Memory, DMA and
// firmware cycles fall back to IDLE and never drive LAD.
//
// Parameters
//   IO_BASE   I/O window base, must be aligned to the window size
//   WIN_BITS  log2 of the window size in bytes (at most 8)
//
// Ports
//   LpcClock    in   1  LPC clock, the only clock
//   PciReset    in   1  synchronous active-high reset
//   LFRAME_n    in   1  LPC frame, active low
//   LAD_in      in   4  LAD as sampled from the pad
//   LAD_out     out  4  LAD drive value
//   LAD_oe      out  1  LAD pad output enable
//   RdData      in   8  register read data for Addr (combinational from Addr)
//   Addr        out  8  register offset inside the window
//   Wr          out  1  one-clock write strobe
//   DataWrSW    out  8  write data
//   Port80Data  out  8  last POST code (only with LPC_PORT80_EN)
//
// Build option
//   LPC_PORT80_EN  Snoops I/O writes to 0x0080 passively into Port80Data. When
//                  this option is undefined, port 0x80 is an ordinary miss.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a frame
// START   | frame seen, next nibble is the cycle type
// ADDR    | collecting four address nibbles, MSN first
// WDATA   | collecting two write-data nibbles, low nibble first
// TAR_H   | two-clock host turnaround, LAD released
// SYNC    | drives ready SYNC (0x0), write strobe fires here
// RDATA   | drives read data low then high nibble
// TAR_P   | peripheral turnaround: drive 0xF, then release
// ---------------------------------------------------------------------------
module lpc_io_decoder #(
    parameter logic [15:0] IO_BASE  = 16'h0700,
    parameter int          WIN_BITS = 5
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_n,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    input  logic [7:0] RdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWrSW
`ifdef LPC_PORT80_EN
    ,
    output logic [7:0] Port80Data
`endif
);

    localparam logic [15:0] WIN_MASK = 16'((32'd1 << WIN_BITS) - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_WDATA,
        ST_TAR_H,
        ST_SYNC,
        ST_RDATA,
        ST_TAR_P
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [11:0] ash_q, ash_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rdat_q, rdat_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  dwr_q, dwr_d;
    logic [3:0]  lad_out_q, lad_out_d;
    logic        lad_oe_q, lad_oe_d;
`ifdef LPC_PORT80_EN
    logic        snoop_q, snoop_d;
    logic [7:0]  p80_q, p80_d;
`endif

    logic [15:0] full_addr;
    logic        hit;

    // The last address nibble is combined straight from the pad so that the
    // window decision is available in the same clock as nibble 4.
    assign full_addr = {ash_q, LAD_in};
    assign hit = ((full_addr & ~WIN_MASK) == (IO_BASE & ~WIN_MASK));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        ash_d   = ash_q;
        data_d  = data_q;
        rdat_d  = rdat_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        dwr_d   = dwr_q;
`ifdef LPC_PORT80_EN
        snoop_d = snoop_q;
        p80_d   = p80_q;
`endif

        if (!LFRAME_n) begin
            // A frame overrides everything, including a peripheral phase.
            state_d = (LAD_in == 4'h0) ? ST_START : ST_IDLE;
            cnt_d   = 2'd0;
`ifdef LPC_PORT80_EN
            snoop_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_START: begin
                    cnt_d = 2'd0;
`ifdef LPC_PORT80_EN
                    snoop_d = 1'b0;
`endif
                    case (LAD_in)
                        4'h0: begin
                            state_d = ST_ADDR;
                            is_wr_d = 1'b0;
                        end
                        4'h2: begin
                            state_d = ST_ADDR;
                            is_wr_d = 1'b1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_ADDR: begin
                    ash_d = {ash_q[7:0], LAD_in};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        if (hit) begin
                            addr_d  = 8'(full_addr & WIN_MASK);
                            state_d = is_wr_q ? ST_WDATA : ST_TAR_H;
                        end
`ifdef LPC_PORT80_EN
                        else if (is_wr_q && full_addr == 16'h0080) begin
                            snoop_d = 1'b1;
                            state_d = ST_WDATA;
                        end
`endif
                        else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (cnt_q == 2'd0) begin
                        data_d[3:0] = LAD_in;
                        cnt_d       = 2'd1;
                    end else begin
                        data_d[7:4] = LAD_in;
                        cnt_d       = 2'd0;
                        state_d     = ST_TAR_H;
                    end
                end
                ST_TAR_H: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                    end else begin
                        cnt_d = 2'd0;
`ifdef LPC_PORT80_EN
                        // Snooped POST writes belong to another target, so we
                        // capture the data and stay off the bus.
                        if (snoop_q) begin
                            p80_d   = data_q;
                            snoop_d = 1'b0;
                            state_d = ST_IDLE;
                        end else
`endif
                        begin
                            state_d = ST_SYNC;
                            if (is_wr_q) begin
                                wr_d  = 1'b1;
                                dwr_d = data_q;
                            end else begin
                                // Addr has been stable since the address phase,
                                // so RdData is settled here.
                                rdat_d = RdData;
                            end
                        end
                    end
                end
                ST_SYNC: begin
                    cnt_d   = 2'd0;
                    state_d = is_wr_q ? ST_TAR_P : ST_RDATA;
                end
                ST_RDATA: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = ST_TAR_P;
                    end
                end
                ST_TAR_P: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end

        // The pad controls are registered from the state being entered, so
        // they line up with the state they belong to.
        lad_oe_d  = 1'b0;
        lad_out_d = 4'hF;
        case (state_d)
            ST_SYNC: begin
                lad_oe_d  = 1'b1;
                lad_out_d = 4'h0;
            end
            ST_RDATA: begin
                lad_oe_d  = 1'b1;
                lad_out_d = cnt_d[0] ? rdat_d[7:4] : rdat_d[3:0];
            end
            ST_TAR_P: begin
                lad_oe_d  = (cnt_d == 2'd0);
                lad_out_d = 4'hF;
            end
            default: begin
                lad_oe_d  = 1'b0;
                lad_out_d = 4'hF;
            end
        endcase
    end

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            is_wr_q   <= 1'b0;
            ash_q     <= 12'h000;
            data_q    <= 8'h00;
            rdat_q    <= 8'h00;
            addr_q    <= 8'h00;
            wr_q      <= 1'b0;
            dwr_q     <= 8'h00;
            lad_out_q <= 4'hF;
            lad_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            ash_q     <= ash_d;
            data_q    <= data_d;
            rdat_q    <= rdat_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            dwr_q     <= dwr_d;
            lad_out_q <= lad_out_d;
            lad_oe_q  <= lad_oe_d;
        end
    end

`ifdef LPC_PORT80_EN
    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            snoop_q <= 1'b0;
            p80_q   <= 8'h00;
        end else begin
            snoop_q <= snoop_d;
            p80_q   <= p80_d;
        end
    end

    assign Port80Data = p80_q;
`endif

    assign LAD_out  = lad_out_q;
    assign LAD_oe   = lad_oe_q;
    assign Addr     = addr_q;
    assign Wr       = wr_q;
    assign DataWrSW = dwr_q;

endmodule

// File: tb/tb_lpc_io_decoder.sv
module tb_lpc_io_decoder;

    localparam logic [15:0] IO_BASE  = 16'h0700;
    localparam logic [5:0]  IDLE_OUT = {1'b0, 4'hF, 1'b0};   // {oe, lad, wr}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lframe_n = 1'b1;
    logic [3:0] lad_in = 4'hF;
    logic [3:0] lad_out;
    logic       lad_oe;
    logic [7:0] rd_data;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] dwr;
`ifdef LPC_PORT80_EN
    logic [7:0] p80;
    logic [7:0] m_p80 = 8'h00;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_dwr  = 8'h00;

    always #15 clk = ~clk;

    // External register mux stand-in: read data is a fixed function of Addr.
    assign rd_data = addr ^ 8'h54;

    lpc_io_decoder #(.IO_BASE(IO_BASE), .WIN_BITS(5)) dut (
        .LpcClock  (clk),
        .PciReset  (rst),
        .LFRAME_n  (lframe_n),
        .LAD_in    (lad_in),
        .LAD_out   (lad_out),
        .LAD_oe    (lad_oe),
        .RdData    (rd_data),
        .Addr      (addr),
        .Wr        (wr),
        .DataWrSW  (dwr)
`ifdef LPC_PORT80_EN
        ,
        .Port80Data(p80)
`endif
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [7:0] reg_model(input logic [15:0] a);
        return {3'b000, a[4:0]} ^ 8'h54;
    endfunction

    function automatic bit is_hit(input logic [15:0] a);
        return a[15:5] == IO_BASE[15:5];
    endfunction

    task automatic step(input logic fr, input logic [3:0] nib, input logic r);
        @(negedge clk);
        lframe_n = fr;
        lad_in   = nib;
        rst      = r;
        @(posedge clk);
        #1;
        obs_q.push_back({lad_oe, lad_out, wr});
    endtask

    // Runs one LPC I/O cycle and pushes the expected pad/strobe values for
    // every clock. stop_at aborts (frame, LAD=F) or resets at that step.
    task automatic bus_cycle(input bit is_wr, input logic [15:0] a,
                             input logic [7:0] d, input int stop_at,
                             input bit stop_rst, input int n_start);
        bit         hit;
        logic [7:0] r;
        logic [3:0] nib;
        logic       fr;
        logic [5:0] e;
        int         end_i;
        hit   = is_hit(a);
        r     = reg_model(a);
        end_i = 13;
        for (int k = 0; k < n_start - 1; k++) begin
            step(1'b0, 4'h0, 1'b0);
            exp_q.push_back(IDLE_OUT);
        end
        for (int i = 0; i < 13; i++) begin
            if (i == stop_at) begin
                end_i = i;
                if (stop_rst) step(1'b1, 4'hF, 1'b1);
                else          step(1'b0, 4'hF, 1'b0);
                exp_q.push_back(IDLE_OUT);
                step(1'b1, 4'hF, 1'b0);
                exp_q.push_back(IDLE_OUT);
                break;
            end
            fr  = (i == 0) ? 1'b0 : 1'b1;
            case (i)
                0:       nib = 4'h0;
                1:       nib = is_wr ? 4'h2 : 4'h0;
                2:       nib = a[15:12];
                3:       nib = a[11:8];
                4:       nib = a[7:4];
                5:       nib = a[3:0];
                6:       nib = is_wr ? d[3:0] : 4'hF;
                7:       nib = is_wr ? d[7:4] : 4'hF;
                default: nib = 4'hF;
            endcase
            e = IDLE_OUT;
            if (hit && is_wr) begin
                if (i == 9)  e = {1'b1, 4'h0, 1'b1};
                if (i == 10) e = {1'b1, 4'hF, 1'b0};
            end else if (hit) begin
                if (i == 7)  e = {1'b1, 4'h0, 1'b0};
                if (i == 8)  e = {1'b1, r[3:0], 1'b0};
                if (i == 9)  e = {1'b1, r[7:4], 1'b0};
                if (i == 10) e = {1'b1, 4'hF, 1'b0};
            end
            step(fr, nib, 1'b0);
            exp_q.push_back(e);
        end
        if (hit && end_i > 5) m_addr = {3'b000, a[4:0]};
        if (hit && is_wr && end_i > 9) m_dwr = d;
`ifdef LPC_PORT80_EN
        if (!hit && is_wr && a == 16'h0080 && end_i > 9) m_p80 = d;
        if (stop_rst && end_i < 13) m_p80 = 8'h00;
`endif
        if (stop_rst && end_i < 13) begin
            m_addr = 8'h00;
            m_dwr  = 8'h00;
        end
    endtask

    task automatic test_reset();
        logic [5:0] e, o;
        step(1'b1, 4'hF, 1'b1);
        exp_q.push_back(IDLE_OUT);
        step(1'b1, 4'hF, 1'b1);
        exp_q.push_back(IDLE_OUT);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_addr: got %h required 00", addr);
        end
        n_chk++;
        if (dwr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dwr: got %h required 00", dwr);
        end
        step(1'b1, 4'hF, 1'b0);
        void'(obs_q.pop_front());
    endtask

    task automatic test_write();
        logic [5:0] e, o;
        bus_cycle(1'b1, 16'h0708, 8'hA5, 99, 1'b0, 1);
        bus_cycle(1'b1, 16'h071E, 8'h3C, 99, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL write_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL write_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    task automatic test_read();
        logic [5:0] e, o;
        bus_cycle(1'b0, 16'h0701, 8'h00, 99, 1'b0, 1);
        bus_cycle(1'b0, 16'h071E, 8'h00, 99, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL read_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL read_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    task automatic test_miss();
        logic [5:0] e, o;
        bus_cycle(1'b1, 16'h0600, 8'h11, 99, 1'b0, 1);
        bus_cycle(1'b0, 16'h0720, 8'h00, 99, 1'b0, 1);
        bus_cycle(1'b1, 16'h06FF, 8'h22, 99, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL miss_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL miss_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    task automatic test_abort();
        logic [5:0] e, o;
        bus_cycle(1'b0, 16'h0701, 8'h00, 9, 1'b0, 1);
        bus_cycle(1'b1, 16'h0702, 8'h99, 7, 1'b0, 1);
        bus_cycle(1'b1, 16'h071F, 8'hC3, 99, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL abort_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    task automatic test_frames();
        logic [5:0] e, o;
        logic [3:0] seq[13];
        // A memory-read cycle type is ignored even with a matching address.
        seq = '{4'h0, 4'h4, 4'h0, 4'h7, 4'h0, 4'h8, 4'hF, 4'hF,
                4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 13; i++) begin
            step((i == 0) ? 1'b0 : 1'b1, seq[i], 1'b0);
            exp_q.push_back(IDLE_OUT);
        end
        // Frame with a non-START nibble goes nowhere.
        step(1'b0, 4'hF, 1'b0);
        exp_q.push_back(IDLE_OUT);
        step(1'b1, 4'h2, 1'b0);
        exp_q.push_back(IDLE_OUT);
        // Repeated START nibbles: the last one opens the cycle.
        bus_cycle(1'b1, 16'h0710, 8'h3E, 99, 1'b0, 3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL frame_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL frame_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e, o;
        bus_cycle(1'b1, 16'h0713, 8'h5A, 10, 1'b1, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL reset_mid_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    task automatic test_port80();
        logic [5:0] e, o;
        bus_cycle(1'b1, 16'h0704, 8'h66, 99, 1'b0, 1);
        bus_cycle(1'b1, 16'h0080, 8'h3C, 99, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL port80_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL port80_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
`ifdef LPC_PORT80_EN
        n_chk++;
        if (p80 !== m_p80) begin
            n_fail++;
            $display("FAIL port80_data: got %h required %h", p80, m_p80);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] e, o;
        bus_cycle(1'b1, 16'h0705, 8'h77, 99, 1'b0, 1);
        bus_cycle(1'b0, 16'h0705, 8'h00, 99, 1'b0, 1);
        bus_cycle(1'b1, 16'h0700, 8'h0F, 99, 1'b0, 1);
        bus_cycle(1'b0, 16'h071A, 8'h00, 99, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : 6'bx;
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_pads: got oe/lad/wr=%b required %b", o, e);
            end
        end
        n_chk++;
        if (addr !== m_addr || dwr !== m_dwr) begin
            n_fail++;
            $display("FAIL b2b_port: got addr=%h data=%h required addr=%h data=%h",
                     addr, dwr, m_addr, m_dwr);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_miss();
        test_abort();
        test_frames();
        test_reset_mid();
        test_port80();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
